// File: rtl/h_mux4_scan_bank.sv
// Four-entry register bank feeding a 4-way mux, with a scan sequencer
// that captures the mux output and streams entries 0..3 over valid/ready.
module h_mux4_scan_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       rd_sel,
  input  logic             scan_start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] mux_out,
  output logic             busy,
  output logic             scan_valid,
  input  logic             scan_ready,
  output logic [WIDTH-1:0] scan_data,
  output logic [1:0]       scan_idx,
  output logic             scan_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       idx_q, idx_d;
  logic             last_q, last_d;
  logic             cap;

  // Capture reads the mux before any same-edge write lands in the bank.
  assign cap = (state_q == SCAN) && (!valid_q || scan_ready);

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    d_d = d_q;
    if (wr_en) begin
      unique case (1'b1)
        (wr_addr == 2'd0): a_d = wr_data;
        (wr_addr == 2'd1): b_d = wr_data;
        (wr_addr == 2'd2): c_d = wr_data;
        (wr_addr == 2'd3): d_d = wr_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (scan_start) state_d = SCAN;
      SCAN:    if (cap && cnt_q == 2'd3) state_d = DRAIN;
      DRAIN:   if (scan_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (state_q == IDLE && scan_start) begin
      cnt_d = '0;
    end
    if (cap) begin
      data_d  = mux_out;
      idx_d   = cnt_q;
      last_d  = (cnt_q == 2'd3);
      valid_d = 1'b1;
      if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
    end else if (state_q != SCAN && scan_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    sel  = (state_q == IDLE) ? rd_sel : cnt_q;
  end

  assign a          = a_q;
  assign b          = b_q;
  assign c          = c_q;
  assign d          = d_q;
  assign scan_valid = valid_q;
  assign scan_data  = data_q;
  assign scan_idx   = idx_q;
  assign scan_last  = last_q;

endmodule

// File: doc/h_mux4_scan_bank.md
# h_mux4_scan_bank

Four-entry 16-bit register bank with a scan sequencer, built as the upstream stage of the 16-bit 4-way mux (hMux4Way16). It holds the four mux data inputs and drives the mux `sel`. It also captures the mux output back and streams all four entries out in order over a valid/ready handshake. It is used for register-file readback and debug dumps in the Hack datapath.

## Interface
- `WIDTH`, 16, data width of each entry, of the mux ports, and of `scan_data`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe for the bank.
- `wr_addr`  in  2  target entry: 0=a, 1=b, 2=c, 3=d.
- `wr_data`  in  WIDTH  write data.
- `rd_sel`  in  2  mux select used while IDLE.
- `scan_start`  in  1  one-cycle request to dump entries 0..3.
- `a`, `b`, `c`, `d`  out  WIDTH each  registered entries, wired to the mux inputs.
- `sel`  out  2  mux select.
- `mux_out`  in  WIDTH  mux output, fed back for capture.
- `busy`  out  1  scan in progress.
- `scan_valid`  out  1  `scan_data` holds a valid beat.
- `scan_ready`  in  1  consumer accepts the beat.
- `scan_data`  out  WIDTH  captured entry value.
- `scan_idx`  out  2  entry index of the current beat.
- `scan_last`  out  1  the current beat is entry 3.

## Operation
- Reset (async, `rst_n`=0): `a`..`d`=0, state=IDLE, scan counter=0, `busy`=0, `scan_valid`=0, `scan_data`=0, `scan_idx`=0, `scan_last`=0. Reset mid-scan aborts the scan immediately, with no further beats.
- Writes: when `wr_en`=1, entry `wr_addr` is loaded at the clock edge. Writes are accepted in every state.
- `sel`: in IDLE, `sel`=`rd_sel` (combinational passthrough). In SCAN, `sel` is the registered scan counter.
- States:
  - IDLE: if `scan_start`=1, go to SCAN, counter=0, `busy`=1.
  - SCAN: a capture happens when (`scan_valid`=0 or `scan_ready`=1).
    - On capture: `scan_data`<=`mux_out`, `scan_idx`<=counter, `scan_last`<=(counter==3), `scan_valid`<=1.
    - If counter<3: counter increments.
    - If counter==3: go to DRAIN.
  - DRAIN: hold the last beat until `scan_ready`=1. Then `scan_valid`<=0, `scan_last`<=0, `busy`<=0, and go to IDLE.
- Outside SCAN: on a `scan_ready`=1 handshake, `scan_valid` clears.
- While stalled (`scan_valid`=1, `scan_ready`=0): `scan_data`, `scan_idx`, `scan_last` and the counter hold.
- `scan_start` while `busy`=1 is ignored. This includes the DRAIN cycle in which `busy` clears.
- Write to the entry being captured in the same cycle: the captured value is the pre-write value. The new value is visible on the mux from the next cycle.

## Timing
- `scan_start` is sampled at edge E0. `busy` and `sel`=0 are visible after E0.
- With `scan_ready` held at 1:
  - beats 0..3 are presented after E1..E4;
  - `scan_last`=1 after E4;
  - `scan_valid` and `busy` drop after E5.
  - Total: 5 cycles from start to IDLE.
- Each cycle of `scan_ready`=0 while `scan_valid`=1 adds exactly one cycle of latency.
- Max throughput is one beat per cycle. There are no bubbles while `scan_ready`=1.
- The mux path is combinational: `sel` → `mux_out` must settle within one cycle.

## Test plan
- Reset, then write a=0x0000, b=0x0001, c=0x0002, d=0x0003, `scan_ready`=1, pulse `scan_start` → beats 0x0000, 0x0001, 0x0002, 0x0003 with `scan_idx` 0..3 on consecutive cycles; `scan_last` only on 0x0003; `busy` high for 5 cycles.
- Same data, `scan_ready` low for 3 cycles at beat 1 → 0x0001 held stable for 4 cycles; order is unchanged; no beat is lost or duplicated.
- IDLE, `rd_sel`=2'b10 with c=0xBEEF → `sel`=2'b10 and `mux_out`=0xBEEF in the same cycle; `scan_valid` stays 0.
- During a scan, write d=0x1234 in the cycle that captures d (old d=0x0003) → beat 3 = 0x0003; `d` reads 0x1234 afterward.
- Pulse `scan_start` again at beat 2 → ignored; exactly 4 beats are produced.
- Assert `rst_n`=0 after beat 1 → all outputs go to 0 asynchronously, the bank is cleared, and a new scan afterward returns four 0x0000 beats.
